// File: rtl/geri_yazma_denetleyici.sv
// Write-back controller: round-robin arbitration onto the register file write port,
// registered write stage and destination busy scoreboard. Optional bypass: GY_ILETIM_EN.
module geri_yazma_denetleyici #(
    parameter int N_ISTEK = 3,
    parameter int ADR_W   = 5
) (
    input  logic                     clk_g,
    input  logic                     rst_n_g,
    input  logic [N_ISTEK-1:0]       istek_gecerli_g,
    input  logic [N_ISTEK*ADR_W-1:0] istek_adres_g,
    input  logic [N_ISTEK*32-1:0]    istek_deger_g,
    output logic [N_ISTEK-1:0]       istek_hazir_c,
    input  logic                     ayir_g,
    input  logic [ADR_W-1:0]         ayir_adres_g,
    input  logic [ADR_W-1:0]         sorgu1_adres_g,
    input  logic [ADR_W-1:0]         sorgu2_adres_g,
    output logic                     mesgul1_c,
    output logic                     mesgul2_c,
    output logic [ADR_W-1:0]         hy_adres_c,
    output logic [31:0]              hy_deger_c,
`ifdef GY_ILETIM_EN
    output logic [31:0]              iletim_deger_c,
    output logic                     iletim1_c,
    output logic                     iletim2_c,
`endif
    output logic                     yaz_c
);

    localparam int PTR_W = $clog2(N_ISTEK);
    localparam int N_REG = 1 << ADR_W;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_any;
    logic [N_ISTEK-1:0] grant;
    logic [ADR_W-1:0] sel_adres;
    logic [31:0]      sel_deger;
    logic [N_REG-1:0] busy;
    logic [N_REG-1:0] busy_next;
    logic             byp1;
    logic             byp2;

    // Scan from the pointer upward with wrap; no grants are shown while reset is held.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        ptr_next  = ptr;
        for (int k = 0; k < N_ISTEK; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_ISTEK) idx = idx - N_ISTEK;
            if (!grant_any && istek_gecerli_g[idx]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
        if (!rst_n_g) grant_any = 1'b0;
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
            ptr_next = (grant_idx == PTR_W'(N_ISTEK - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign istek_hazir_c = grant;
    assign sel_adres     = istek_adres_g[grant_idx*ADR_W +: ADR_W];
    assign sel_deger     = istek_deger_g[grant_idx*32 +: 32];

    // Address 0 still loads the stage but never raises the write enable.
    always_ff @(posedge clk_g or negedge rst_n_g) begin
        if (!rst_n_g) begin
            ptr        <= '0;
            yaz_c      <= 1'b0;
            hy_adres_c <= '0;
            hy_deger_c <= '0;
        end else begin
            yaz_c <= grant_any && (sel_adres != '0);
            if (grant_any) begin
                ptr        <= ptr_next;
                hy_adres_c <= sel_adres;
                hy_deger_c <= sel_deger;
            end
        end
    end

    // Clear is applied before set so a same-cycle reservation wins.
    always_comb begin
        busy_next = busy;
        if (yaz_c) busy_next[hy_adres_c] = 1'b0;
        if (ayir_g) busy_next[ayir_adres_g] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_g or negedge rst_n_g) begin
        if (!rst_n_g) busy <= '0;
        else          busy <= busy_next;
    end

`ifdef GY_ILETIM_EN
    assign iletim1_c      = yaz_c && (hy_adres_c == sorgu1_adres_g) && (sorgu1_adres_g != '0);
    assign iletim2_c      = yaz_c && (hy_adres_c == sorgu2_adres_g) && (sorgu2_adres_g != '0);
    assign iletim_deger_c = hy_deger_c;
    assign byp1           = iletim1_c;
    assign byp2           = iletim2_c;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign mesgul1_c = busy[sorgu1_adres_g] && !byp1;
    assign mesgul2_c = busy[sorgu2_adres_g] && !byp2;

endmodule
